updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised modulo up/down counter with synchronous clear, parallel load, wrap or saturate mode, a combinational terminal-count carry for cascading and a sticky overflow flag. It is the general-purpose counting primitive for timers, address generators and event counters. It replaces fixed 4-bit up-only counters wherever width, modulus, direction or load is needed.

## Interface
Parameters:
- WIDTH, 8, count register width in bits (1..32)
- MODULO, 2**WIDTH, count range is 0..MODULO-1; legal range 2..2**WIDTH
- PRESCALE, 4, enabled cycles per count step; used only with UDC_PRESCALE_EN; legal range 2..65536

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low. The clock port is `clk` and the reset port is `rst_n`.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- sat  in  1  boundary mode: 0 = wrap, 1 = saturate
- clr  in  1  synchronous clear of count, ovf and prescaler
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  load value
- count  out  WIDTH  current count, registered
- tc  out  1  terminal count / carry-out, combinational
- ovf  out  1  sticky boundary flag, registered

## Operation
- MAX = MODULO-1.
- step = en & tick. Without the prescaler, tick = 1.
- Priority each edge is clr > load > step > hold.
- clr: count <= 0, ovf <= 0, prescaler <= 0.
- load: count <= (load_val > MAX) ? MAX : load_val. The prescaler is set to 0 and ovf is unchanged.
- Boundary step: a step with (up & count==MAX) or (~up & count==0).
- Normal step up: count <= count+1.
- Normal step down: count <= count-1.
- Boundary step with sat=0 (wrap): up gives count <= 0; down gives count <= MAX.
- Boundary step with sat=1: count holds at MAX (up) or 0 (down).
- Any boundary step sets ovf <= 1 in both modes. ovf is cleared only by clr or reset.
- tc = step & ~clr & ~load & boundary. It flags the carry/borrow for a cascaded next stage in the same cycle.
- When MODULO = 2**WIDTH, wrap uses natural modulo-2^WIDTH arithmetic. No intermediate value may exceed WIDTH bits.
- Non-power-of-2 MODULO uses an explicit compare against MAX. count never holds a value above MAX.
- en, up and sat are sampled every cycle. A direction change takes effect on the next step with no penalty.

## Timing
- Reset (rst_n low, asynchronous): count = 0, ovf = 0, prescaler = 0. Outputs are valid immediately, independent of clk.
- Reset release is synchronous to the next clk edge. The first step can occur on the first rising edge with rst_n high.
- Reset asserted mid-count: count drops to 0 without waiting for an edge.
- Latency:
  - count updates 1 cycle after a step, clr or load.
  - ovf sets on the same edge as the boundary step.
  - tc is combinational from en/up/count/clr/load, with no registered delay.
- Simultaneous events:
  - clr + load: clr wins.
  - load + en: load wins and the step is lost.
  - clr on a boundary step: ovf ends at 0.

## Configuration
- UDC_PRESCALE_EN defined:
  - Adds an internal ceil(log2(PRESCALE))-bit prescaler that counts cycles with en=1.
  - tick = 1 when the prescaler equals PRESCALE-1 and en=1; the prescaler then returns to 0.
  - The count therefore advances once per PRESCALE enabled cycles.
  - The prescaler holds when en=0 and resets on rst_n, clr and load.
- UDC_PRESCALE_EN undefined:
  - No prescaler logic is built and PRESCALE is ignored.
  - tick = 1, so the count advances every cycle with en=1.

## Test plan
- WIDTH=4, MODULO=16, sat=0, up=1, en=1 for 17 cycles from reset -> count 0..15 then 0. tc is high only in the cycle count=15. ovf rises at the 15->0 edge and stays 1.
- WIDTH=4, MODULO=10, up=0, sat=0 from count=0 -> count sequence 9,8,…,0,9. The value 15 never appears.
- WIDTH=4, MODULO=10, load_val=13 with load=1 -> count=9. Then sat=1, up=1, en=1 for 3 cycles -> count stays 9, tc=1 each cycle, ovf=1.
- clr=1 and load=1 together with count=5 and ovf=1 -> count=0, ovf=0. Also, rst_n pulsed low between edges at count=7 -> count=0 immediately.
- UDC_PRESCALE_EN, PRESCALE=4, en=1 for 12 cycles -> count goes 0→3, stepping every 4th cycle. Dropping en for 2 cycles mid-period delays the next step by exactly 2 cycles.
- Cascade two instances, carry-in of the high stage = tc of the low stage, WIDTH=4, MODULO=16, up=1 -> the combined 8-bit value increments 0x0F→0x10 in one cycle.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param
// Parametrised modulo up/down counter with synchronous clear, parallel load,
// wrap or saturate at the boundaries, a combinational terminal-count carry
// for cascading and a sticky overflow flag.
//
// Optional feature macro: UDC_PRESCALE_EN
//   defined   -> an internal prescaler lets the count advance once per
//                PRESCALE enabled cycles
//   undefined -> the count advances on every enabled cycle; PRESCALE unused
module updown_counter_param #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter int unsigned     PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // MODULO is at most 2**WIDTH, so MAX always fits in WIDTH bits and the
    // power-of-2 case needs no special handling.
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             step;
    logic             boundary;

`ifdef UDC_PRESCALE_EN
    localparam int unsigned    PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescaler wraps on the last enabled cycle of a period; clr/load restart it.
    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = ps_q;
        if (clr || load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = tick ? '0 : ps_q + PS_ONE;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    // PRESCALE is always >= 2, so this is a constant 1: every enabled cycle steps.
    assign tick = (PRESCALE >= 2);
`endif

    assign step     = en & tick;
    assign boundary = up ? (count_q == MAX) : (count_q == ZERO);
    assign tc       = step & ~clr & ~load & boundary;

    // Next count / overflow with priority clr > load > step > hold.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = ZERO;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX) ? MAX : load_val;
        end else if (step) begin
            if (boundary) begin
                ovf_d = 1'b1;
                if (!sat) begin
                    count_d = up ? ZERO : MAX;
                end
            end else begin
                count_d = up ? count_q + ONE : count_q - ONE;
            end
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    logic       clk;
    logic       rst_n;
    logic       en, up, sat, clr, load;
    logic [3:0] load_val;
    logic [3:0] count16, count10;
    logic       tc16, tc10, ovf16, ovf10;

    logic       c_en, c_clr, c_load;
    logic [3:0] c_lv_lo, c_lv_hi;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, hi_tc, lo_ovf, hi_ovf;

    int checks;
    int failures;

    updown_counter_param #(.WIDTH(4), .MODULO(16), .PRESCALE(4)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .load_val(load_val), .count(count16), .tc(tc16), .ovf(ovf16)
    );

    updown_counter_param #(.WIDTH(4), .MODULO(10), .PRESCALE(4)) u10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .load_val(load_val), .count(count10), .tc(tc10), .ovf(ovf10)
    );

    updown_counter_param #(.WIDTH(4), .MODULO(16), .PRESCALE(4)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .sat(1'b0), .clr(c_clr),
        .load(c_load), .load_val(c_lv_lo), .count(lo_count), .tc(lo_tc), .ovf(lo_ovf)
    );

    updown_counter_param #(.WIDTH(4), .MODULO(16), .PRESCALE(4)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(lo_tc), .up(1'b1), .sat(1'b0), .clr(c_clr),
        .load(c_load), .load_val(c_lv_hi), .count(hi_count), .tc(hi_tc), .ovf(hi_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 0; up = 1; sat = 0; clr = 0; load = 0; load_val = 0;
        c_en = 0; c_clr = 0; c_load = 0; c_lv_lo = 0; c_lv_hi = 0;
        #2;
        checks++; if (count16 !== 4'd0) begin failures++; $display("FAIL reset_count16 got=%0d exp=0", count16); end
        checks++; if (count10 !== 4'd0) begin failures++; $display("FAIL reset_count10 got=%0d exp=0", count10); end
        checks++; if (ovf16 !== 1'b0 || ovf10 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b%0b exp=00", ovf16, ovf10); end
        checks++; if ({hi_count, lo_count} !== 8'h00) begin failures++; $display("FAIL reset_cascade got=%0h exp=0", {hi_count, lo_count}); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap_up16();
        en = 1; up = 1; sat = 0;
        #1;
        for (int i = 0; i <= 16; i++) begin
            checks++; if (count16 !== 4'(i % 16)) begin failures++; $display("FAIL wrap16_count i=%0d got=%0d exp=%0d", i, count16, i % 16); end
            checks++; if (tc16 !== (i == 15)) begin failures++; $display("FAIL wrap16_tc i=%0d got=%0b exp=%0b", i, tc16, (i == 15)); end
            checks++; if (ovf16 !== (i >= 16)) begin failures++; $display("FAIL wrap16_ovf i=%0d got=%0b exp=%0b", i, ovf16, (i >= 16)); end
            if (i < 16) tick();
        end
        tick();
        checks++; if (count16 !== 4'd1 || ovf16 !== 1'b1) begin failures++; $display("FAIL wrap16_sticky got=%0d/%0b exp=1/1", count16, ovf16); end
        en = 0;
    endtask

    task automatic test_down_mod10();
        int e;
        clr = 1; tick(); clr = 0;
        checks++; if (count10 !== 4'd0 || ovf10 !== 1'b0) begin failures++; $display("FAIL down10_clr got=%0d/%0b exp=0/0", count10, ovf10); end
        en = 1; up = 0; sat = 0;
        #1;
        e = 0;
        for (int k = 0; k < 11; k++) begin
            checks++; if (tc10 !== (e == 0)) begin failures++; $display("FAIL down10_tc k=%0d got=%0b exp=%0b", k, tc10, (e == 0)); end
            tick();
            e = (e == 0) ? 9 : e - 1;
            checks++; if (count10 !== 4'(e)) begin failures++; $display("FAIL down10_count k=%0d got=%0d exp=%0d", k, count10, e); end
        end
        checks++; if (ovf10 !== 1'b1) begin failures++; $display("FAIL down10_ovf got=%0b exp=1", ovf10); end
        en = 0;
    endtask

    task automatic test_load_sat();
        int e16;
        clr = 1; tick(); clr = 0;
        load = 1; load_val = 4'd13; tick(); load = 0;
        checks++; if (count10 !== 4'd9) begin failures++; $display("FAIL load_clamp10 got=%0d exp=9", count10); end
        checks++; if (count16 !== 4'd13) begin failures++; $display("FAIL load16 got=%0d exp=13", count16); end
        checks++; if (ovf10 !== 1'b0) begin failures++; $display("FAIL load_ovf10 got=%0b exp=0", ovf10); end
        sat = 1; up = 1; en = 1;
        #1;
        e16 = 13;
        for (int k = 0; k < 3; k++) begin
            checks++; if (tc10 !== 1'b1) begin failures++; $display("FAIL sat10_tc k=%0d got=%0b exp=1", k, tc10); end
            checks++; if (tc16 !== (e16 == 15)) begin failures++; $display("FAIL sat16_tc k=%0d got=%0b exp=%0b", k, tc16, (e16 == 15)); end
            tick();
            if (e16 < 15) e16++;
            checks++; if (count10 !== 4'd9) begin failures++; $display("FAIL sat10_count k=%0d got=%0d exp=9", k, count10); end
            checks++; if (count16 !== 4'(e16)) begin failures++; $display("FAIL sat16_count k=%0d got=%0d exp=%0d", k, count16, e16); end
        end
        checks++; if (ovf10 !== 1'b1 || ovf16 !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b%0b exp=11", ovf10, ovf16); end
        load = 1; load_val = 4'd3;
        #1;
        checks++; if (tc10 !== 1'b0) begin failures++; $display("FAIL load_en_tc got=%0b exp=0", tc10); end
        tick();
        checks++; if (count10 !== 4'd3) begin failures++; $display("FAIL load_en_count got=%0d exp=3", count10); end
        load = 0; en = 0; sat = 0;
    endtask

    task automatic test_clr_load();
        load = 1; load_val = 4'd5; tick(); load = 0;
        checks++; if (count10 !== 4'd5 || ovf10 !== 1'b1) begin failures++; $display("FAIL pre_clr got=%0d/%0b exp=5/1", count10, ovf10); end
        clr = 1; load = 1; load_val = 4'd7; tick(); clr = 0; load = 0;
        checks++; if (count10 !== 4'd0 || ovf10 !== 1'b0) begin failures++; $display("FAIL clr_load got=%0d/%0b exp=0/0", count10, ovf10); end
        load = 1; load_val = 4'd9; tick(); load = 0;
        up = 1; en = 1; clr = 1;
        #1;
        checks++; if (tc10 !== 1'b0) begin failures++; $display("FAIL clr_boundary_tc got=%0b exp=0", tc10); end
        tick();
        checks++; if (count10 !== 4'd0 || ovf10 !== 1'b0) begin failures++; $display("FAIL clr_boundary got=%0d/%0b exp=0/0", count10, ovf10); end
        clr = 0; en = 0;
    endtask

    task automatic test_async_reset();
        load = 1; load_val = 4'd7; tick(); load = 0;
        checks++; if (count10 !== 4'd7) begin failures++; $display("FAIL async_pre got=%0d exp=7", count10); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (count10 !== 4'd0 || count16 !== 4'd0) begin failures++; $display("FAIL async_reset got=%0d/%0d exp=0/0", count10, count16); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_direction();
        load = 1; load_val = 4'd4; tick(); load = 0;
        en = 1; up = 1; tick();
        checks++; if (count10 !== 4'd5) begin failures++; $display("FAIL dir_up got=%0d exp=5", count10); end
        up = 0; tick();
        checks++; if (count10 !== 4'd4) begin failures++; $display("FAIL dir_down1 got=%0d exp=4", count10); end
        tick();
        checks++; if (count10 !== 4'd3) begin failures++; $display("FAIL dir_down2 got=%0d exp=3", count10); end
        up = 1; tick();
        checks++; if (count10 !== 4'd4) begin failures++; $display("FAIL dir_up2 got=%0d exp=4", count10); end
        en = 0;
    endtask

    task automatic test_cascade();
        c_clr = 1; tick(); c_clr = 0;
        c_load = 1; c_lv_lo = 4'hE; c_lv_hi = 4'h0; tick(); c_load = 0;
        checks++; if ({hi_count, lo_count} !== 8'h0E) begin failures++; $display("FAIL casc_load got=%0h exp=0e", {hi_count, lo_count}); end
        c_en = 1;
        #1;
        checks++; if (lo_tc !== 1'b0) begin failures++; $display("FAIL casc_tc0 got=%0b exp=0", lo_tc); end
        tick();
        checks++; if ({hi_count, lo_count} !== 8'h0F) begin failures++; $display("FAIL casc_0f got=%0h exp=0f", {hi_count, lo_count}); end
        checks++; if (lo_tc !== 1'b1) begin failures++; $display("FAIL casc_tc1 got=%0b exp=1", lo_tc); end
        tick();
        checks++; if ({hi_count, lo_count} !== 8'h10) begin failures++; $display("FAIL casc_10 got=%0h exp=10", {hi_count, lo_count}); end
        tick();
        checks++; if ({hi_count, lo_count} !== 8'h11) begin failures++; $display("FAIL casc_11 got=%0h exp=11", {hi_count, lo_count}); end
        c_en = 0;
    endtask

    task automatic test_prescale();
        en = 1; up = 1; sat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (count16 !== 4'(k / 4)) begin failures++; $display("FAIL ps_count k=%0d got=%0d exp=%0d", k, count16, k / 4); end
        end
        tick(); tick();
        en = 0; tick(); tick();
        checks++; if (count16 !== 4'd3) begin failures++; $display("FAIL ps_hold got=%0d exp=3", count16); end
        en = 1; tick();
        checks++; if (count16 !== 4'd3) begin failures++; $display("FAIL ps_resume1 got=%0d exp=3", count16); end
        tick();
        checks++; if (count16 !== 4'd4) begin failures++; $display("FAIL ps_resume2 got=%0d exp=4", count16); end
        en = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
`ifdef UDC_PRESCALE_EN
        test_prescale();
`else
        test_wrap_up16();
        test_down_mod10();
        test_load_sat();
        test_clr_load();
        test_async_reset();
        test_direction();
        test_cascade();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
